// File: rtl/alu_bit_serial_sequencer_if.sv
// Request, result and slice signals of the bit-serial ALU sequencer.
// The sequencer uses the slave modport; requester, consumer and slice use master.
interface alu_bit_serial_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_cmd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout;
  logic             out_overflow;
  logic             out_zero;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [2:0]       slice_ctl;
  logic             slice_sum;
  logic             slice_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready, slice_sum, slice_cout,
    output in_ready, out_valid, out_result, out_carryout, out_overflow, out_zero,
    output slice_a, slice_b, slice_cin, slice_ctl
  );

  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready, slice_sum, slice_cout,
    input  in_ready, out_valid, out_result, out_carryout, out_overflow, out_zero,
    input  slice_a, slice_b, slice_cin, slice_ctl
  );
endinterface

// File: rtl/alu_bit_serial_sequencer.sv
// Drives an external 1-bit ALU slice LSB first over WIDTH cycles, collecting the
// result and computing carry/overflow/zero flags; valid/ready on both sides.
module alu_bit_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                         clk,
  input logic                         reset_n,
  alu_bit_serial_sequencer_if.slave   bus_io
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  localparam logic [2:0] CmdAdd = 3'd0;
  localparam logic [2:0] CmdSub = 3'd1;
  localparam logic [2:0] CmdSlt = 3'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [2:0]        cmd_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  result_q;
  logic              carryout_q;
  logic              overflow_q;
  logic              zero_q;

  logic [WIDTH-1:0]  result_d;
  logic              ovf_d;
  logic              zero_d;
  logic              arith;
  logic              is_slt;
  logic              last_bit;

  always_comb begin
    arith    = (cmd_q == CmdAdd) || (cmd_q == CmdSub);
    is_slt   = (cmd_q == CmdSlt);
    last_bit = (idx_q == LastIdx);
    // Overflow of the signed add/sub: carry into the MSB differs from carry out.
    ovf_d    = carry_q ^ bus_io.slice_cout;
    result_d = result_q;
    result_d[idx_q] = bus_io.slice_sum;
    if (last_bit && is_slt) begin
      result_d    = '0;
      result_d[0] = bus_io.slice_sum ^ ovf_d;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            a_q     <= bus_io.in_a;
            b_q     <= bus_io.in_b;
            cmd_q   <= bus_io.in_cmd;
            idx_q   <= '0;
            carry_q <= (bus_io.in_cmd == CmdSub) || (bus_io.in_cmd == CmdSlt);
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q <= result_d;
          carry_q  <= bus_io.slice_cout;
          if (last_bit) begin
            carryout_q <= arith ? bus_io.slice_cout : 1'b0;
            overflow_q <= arith ? ovf_d : 1'b0;
            zero_q     <= zero_d;
            state_q    <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus_io.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic running;
  assign running = (state_q == StRun);

  assign bus_io.in_ready     = (state_q == StIdle);
  assign bus_io.out_valid    = (state_q == StDone);
  assign bus_io.out_result   = result_q;
  assign bus_io.out_carryout = carryout_q;
  assign bus_io.out_overflow = overflow_q;
  assign bus_io.out_zero     = zero_q;

  assign bus_io.slice_a   = running ? a_q[idx_q] : 1'b0;
  assign bus_io.slice_b   = running ? b_q[idx_q] : 1'b0;
  assign bus_io.slice_cin = running ? carry_q : 1'b0;
  assign bus_io.slice_ctl = running ? cmd_q : 3'd0;

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Directed bench for alu_bit_serial_sequencer with a behavioural 1-bit ALU slice.
module tb_alu_bit_serial_sequencer;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  alu_bit_serial_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_bit_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: b inverted for SUB/SLT; logic ops give a nonzero cout on purpose.
  logic sb;
  always_comb begin
    sb = ((bus.slice_ctl == 3'd1) || (bus.slice_ctl == 3'd3)) ? ~bus.slice_b : bus.slice_b;
    bus.slice_sum  = 1'b0;
    bus.slice_cout = 1'b0;
    case (bus.slice_ctl)
      3'd0, 3'd1, 3'd3: begin
        bus.slice_sum  = bus.slice_a ^ sb ^ bus.slice_cin;
        bus.slice_cout = (bus.slice_a & sb) | (bus.slice_a & bus.slice_cin) |
                         (sb & bus.slice_cin);
      end
      3'd2: begin
        bus.slice_sum  = bus.slice_a ^ bus.slice_b;
        bus.slice_cout = bus.slice_a | bus.slice_b;
      end
      3'd4: begin
        bus.slice_sum  = bus.slice_a & bus.slice_b;
        bus.slice_cout = bus.slice_a | bus.slice_b;
      end
      3'd5: begin
        bus.slice_sum  = ~(bus.slice_a & bus.slice_b);
        bus.slice_cout = bus.slice_a | bus.slice_b;
      end
      3'd6: begin
        bus.slice_sum  = ~(bus.slice_a | bus.slice_b);
        bus.slice_cout = bus.slice_a | bus.slice_b;
      end
      default: begin
        bus.slice_sum  = bus.slice_a | bus.slice_b;
        bus.slice_cout = bus.slice_a | bus.slice_b;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns cycles from the accepting edge until out_valid is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n--;
  endtask

  task automatic check_result(input string tag, input logic [31:0] res, input logic c,
                              input logic v, input logic z);
    check({tag, "_res"}, 64'(bus.out_result), 64'(res));
    check({tag, "_c"}, 64'(bus.out_carryout), 64'(c));
    check({tag, "_v"}, 64'(bus.out_overflow), 64'(v));
    check({tag, "_z"}, 64'(bus.out_zero), 64'(z));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_vld_after"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic c,
                        input logic v, input logic z);
    int n;
    start_op(cmd, a, b);
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'(WIDTH));
    check_result(tag, res, c, v, z);
    release_result(tag);
  endtask

  logic [2:0]  lcmd [5];
  logic [31:0] lres [5];

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cmd    = '0;
    bus.out_ready = 1'b0;
    lcmd = '{3'd4, 3'd5, 3'd7, 3'd6, 3'd2};
    lres = '{32'hF000F000, 32'h0FFF0FFF, 32'hFFF0FFF0, 32'h000F000F, 32'h0FF00FF0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.out_result), 64'd0);
    check("rst_slice", 64'({bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_ctl}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("sub_eq", 3'd1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg", 3'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op("slt_ovf", 3'd3, 32'h80000000, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op("slt_no", 3'd3, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("logic%0d", lcmd[i]), lcmd[i], 32'hF0F0F0F0, 32'hFF00FF00, lres[i],
             1'b0, 1'b0, 1'b0);
    end

    // Backpressure: hold DONE, pulse a request that must be ignored.
    start_op(3'd0, 32'h10, 32'h20);
    wait_done(n);
    check("bp_lat", 64'(n), 64'(WIDTH));
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h1234;
        bus.in_cmd   = 3'd7;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check_result("bp", 32'h30, 1'b0, 1'b0, 1'b0);
    release_result("bp");
    run_op("bp_next", 3'd0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation at bit 17.
    start_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (17) @(posedge clk);
    #1;
    check("mid_slice_a", 64'(bus.slice_a), 64'd1);
    check("mid_slice_cin", 64'(bus.slice_cin), 64'd1);
    check("mid_in_ready", 64'(bus.in_ready), 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_slice", 64'({bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_ctl}), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 3'd0, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bit_serial_sequencer.md
Name: alu_bit_serial_sequencer

Overview:
- Runs a full WIDTH-bit ALU operation by driving one external single-bit ALU slice, one bit per clock, LSB first.
- Registers the slice carry between bits, collects the sum bits into the result, and computes the flags.
- Sits upstream and downstream of the slice: it feeds the slice its a/b/carry-in/control and consumes its sum/carryout.
- Uses valid/ready handshakes on both the request side and the result side.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset; one clock, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cmd  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- out_valid  output  1  result valid (DONE state).
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  operation result.
- out_carryout  output  1  carry out of the MSB (ADD/SUB only, else 0).
- out_overflow  output  1  signed overflow (ADD/SUB only, else 0).
- out_zero  output  1  out_result == 0.
- slice_a  output  1  operand A bit to the slice.
- slice_b  output  1  operand B bit to the slice (uninverted; the slice inverts for SUB/SLT).
- slice_cin  output  1  carry into the slice.
- slice_ctl  output  3  command to the slice.
- slice_sum  input  1  slice result bit (combinational from slice_* outputs).
- slice_cout  input  1  slice carry out.

Behaviour:
- State machine: IDLE, RUN, DONE.
- Reset (asynchronous, reset_n low):
  - state=IDLE; result, flags, bit index, carry and the captured operands cleared.
  - out_valid=0; in_ready=1 (combinational from state); slice_* outputs 0.
  - An operation in flight is discarded; no partial result is ever presented.
- IDLE:
  - When in_valid is high, capture in_a, in_b and in_cmd on the edge, and set idx=0.
  - Initial carry = 1 for SUB/SLT, else 0. Go to RUN.
  - Inputs are not sampled in any other state.
- RUN, each cycle:
  - Drive slice_a=a_q[idx], slice_b=b_q[idx], slice_cin=carry_q, slice_ctl=cmd_q.
  - On the edge: result_q[idx]<=slice_sum; carry_q<=slice_cout.
  - When idx==WIDTH-1, also latch cin_msb=carry_q and cout_msb=slice_cout, then go to DONE. Otherwise idx<=idx+1.
  - The idx counter is $clog2(WIDTH) bits and never wraps, because it stops at WIDTH-1.
- On entry to DONE, finalise the flags:
  - overflow = cin_msb XOR cout_msb (ADD/SUB).
  - SLT: out_result = zero-extended (sum_msb XOR overflow); carryout and overflow forced to 0.
  - Logic ops: carryout and overflow forced to 0.
  - out_zero is computed from the final out_result.
- DONE:
  - out_valid=1; result and flags held stable until out_ready.
  - When out_ready is high, go to IDLE on the next edge; out_valid falls.
  - A new request cannot be accepted in the same cycle.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Minimum spacing between accepts is WIDTH+2 cycles.
- Slice outputs are 0 in IDLE and DONE.
- in_valid asserted while in_ready=0 is ignored; the requester must hold the request until it is accepted.
- out_ready asserted outside DONE has no effect.
- Outputs out_result and the flags are registered; in_ready and out_valid decode the state directly.

Test Plan:
- Use WIDTH=32 for all scenarios below.
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carryout 0, overflow 1, zero 0; out_valid rises 32 cycles after accept.
- SUB 0x00000005 - 0x00000005 -> 0x00000000, zero 1, carryout 1, overflow 0. SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carryout 0.
- SLT:
  - (0x80000000, 0x00000001) -> 0x00000001 (overflow-corrected compare).
  - (0x00000001, 0xFFFFFFFF) -> 0x00000000, carryout 0, overflow 0.
- Logic ops with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000; NAND -> 0x0FFF0FFF.
  - OR -> 0xFFF0FFF0; NOR -> 0x000F000F.
  - XOR -> 0x0FF00FF0.
  - All five report flags carryout=0 and overflow=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready 0, pulsed in_valid ignored.
  - Raise out_ready -> IDLE next edge, and the following request is accepted normally.
- Reset mid-operation:
  - Drop reset_n while idx=17 of an ADD -> out_valid=0, in_ready=1 and slice_* 0 immediately, without waiting for a clock edge.
  - After release, a new ADD 3+4 returns 0x00000007 with correct latency.
